// File: rtl/e_pkg.sv
// ============================================================================
// Module   : e_pkg
// Purpose  : Shared sizing helpers for the e_alloc slot allocator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package e_pkg;

    // Count width that can hold the values 0..w inclusive.
    function automatic int e_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    // Pool widths the e_cell selector is built for.
    function automatic bit e_width_ok(input int w);
        return (w >= 4) && (w <= 6);
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_cell.sv
// ============================================================================
// Module   : e_cell
// Purpose  : Next-slot selector: highest free bit of x_i strictly below the
//            one-hot position sel_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_cell #(
    parameter int W = 4
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] sel_i,
    output logic         vld_o,
    output logic [W-1:0] y_o
);

    logic [W-1:0] w_below;
    logic [W-1:0] w_cand;
    logic         w_found;

    // sel_i is one-hot, so sel_i-1 is exactly the set of bits below it.
    assign w_below = (sel_i == '0) ? '0 : (sel_i - W'(1));
    assign w_cand  = ~x_i & w_below;
    assign vld_o   = |w_cand;

    always_comb begin
        y_o     = '0;
        w_found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!w_found && w_cand[i]) begin
                y_o[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/e_prio.sv
// ============================================================================
// Module   : e_prio
// Purpose  : MSB-first one-hot priority encoder (all-zero in, all-zero out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_prio #(
    parameter int W = 4
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    logic w_found;

    always_comb begin
        y_o     = '0;
        w_found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!w_found && x_i[i]) begin
                y_o[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/e_alloc.sv
// ============================================================================
// Module   : e_alloc
// Purpose  : Registered slot allocator around e_cell with one-cycle grant,
//            single-slot release and occupancy status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_alloc
    import e_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  alloc_req_i,
    output logic                  gnt_vld_o,
    output logic                  gnt_ok_o,
    output logic [W-1:0]          gnt_pos_o,
    input  logic                  free_vld_i,
    input  logic [W-1:0]          free_pos_i,
    output logic                  err_o,
    output logic [W-1:0]          occ_o,
    output logic [e_cnt_w(W)-1:0] cnt_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int c_CNT_W = e_cnt_w(W);

    generate
        if (!e_width_ok(W)) begin : g_bad_width
            $error("e_alloc: unsupported pool width W=%0d", W);
        end
    endgenerate

    logic [W-1:0]       r_occ;
    logic [W-1:0]       r_head;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_gnt_vld;
    logic               r_gnt_ok;
    logic [W-1:0]       r_gnt_pos;
    logic               r_err;

    logic               w_cell_vld;
    logic [W-1:0]       w_cell_y;
    logic               w_free_onehot;
    logic               w_free_legal;
    logic [W-1:0]       w_free_mask;
    logic [W-1:0]       w_grant;
    logic [W-1:0]       w_occ_nxt;
    logic [W-1:0]       w_head_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // Selector sees only registered state, so no input reaches it.
    e_cell #(.W(W)) u_cell (
        .x_i   (r_occ),
        .sel_i (r_head),
        .vld_o (w_cell_vld),
        .y_o   (w_cell_y)
    );

    e_prio #(.W(W)) u_prio (
        .x_i (w_occ_nxt),
        .y_o (w_head_nxt)
    );

    assign w_free_onehot = (free_pos_i != '0) && ((free_pos_i & (free_pos_i - W'(1))) == '0);
    assign w_free_legal  = free_vld_i && w_free_onehot && ((free_pos_i & r_occ) != '0);
    assign w_free_mask   = w_free_legal ? free_pos_i : '0;

    always_comb begin
        w_grant = '0;
        if (alloc_req_i) begin
            if (r_occ == '0) begin
                w_grant = {1'b1, {(W-1){1'b0}}};
            end else if (w_cell_vld) begin
                w_grant = w_cell_y;
            end
        end
    end

    // Decision used pre-free occupancy; a granted slot is never the freed one.
    assign w_occ_nxt = (r_occ & ~w_free_mask) | w_grant;

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < W; i++) begin
            w_cnt_nxt = w_cnt_nxt + c_CNT_W'(w_occ_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_occ     <= '0;
            r_head    <= '0;
            r_cnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_ok  <= 1'b0;
            r_gnt_pos <= '0;
            r_err     <= 1'b0;
        end else begin
            r_occ     <= w_occ_nxt;
            r_head    <= w_head_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt_vld <= alloc_req_i;
            r_gnt_ok  <= (w_grant != '0);
            r_gnt_pos <= w_grant;
            r_err     <= free_vld_i && !w_free_legal;
        end
    end

    assign gnt_vld_o = r_gnt_vld;
    assign gnt_ok_o  = r_gnt_ok;
    assign gnt_pos_o = r_gnt_pos;
    assign err_o     = r_err;
    assign occ_o     = r_occ;
    assign cnt_o     = r_cnt;
    assign full_o    = &r_occ;
    assign empty_o   = ~|r_occ;

endmodule

`default_nettype wire

// File: doc/e_alloc.md
Name: e_alloc

Overview:
- Sequential slot allocator built around the e_cell next-slot selector.
- Holds a W-bit occupancy vector and a one-hot head pointer, and drives these into e_cell as x_i and sel_i.
- Consumes e_cell's vld_o/y_o to grant one slot per request, registered.
- Accepts one slot release per cycle and keeps count/full/empty status for the downstream issue logic.

Parameters:
- W, 4, pool width in slots; must be a width e_cell supports (4, 5, 6), otherwise elaboration error.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- alloc_req_i  in  1  allocation request, sampled each cycle
- gnt_vld_o  out  1  grant response valid, one cycle after request
- gnt_ok_o  out  1  qualifies gnt_vld_o: 1 = slot granted, 0 = no slot available
- gnt_pos_o  out  W  one-hot granted slot; all-zero when gnt_ok_o=0
- free_vld_i  in  1  release request
- free_pos_i  in  W  one-hot slot to release
- err_o  out  1  one-cycle pulse on an illegal free
- occ_o  out  W  registered occupancy vector
- cnt_o  out  $clog2(W)+1  number of occupied slots
- full_o  out  1  occ_o all ones
- empty_o  out  1  occ_o all zeros

Behaviour:
- Reset (arst_n low, asynchronous):
  - occ=0, head=0, cnt_o=0.
  - gnt_vld_o=0, gnt_ok_o=0, gnt_pos_o=0, err_o=0.
  - empty_o=1, full_o=0.
- Head pointer invariant: head = one-hot of the highest set bit of occ, MSB-first; head=0 when occ=0. It is recomputed from next-state occupancy on every update.
- Selector hookup: e_cell x_i=occ, sel_i=head, both registered. There is no combinational path from any input port to e_cell.
- Alloc decision (cycle N, alloc_req_i=1), using start-of-cycle occ:
  - occ==0: grant bit W-1.
  - occ!=0 and e_cell vld_o=1: grant y_o.
  - otherwise: fail.
- Alloc response (cycle N+1, all registered):
  - gnt_vld_o=1.
  - gnt_ok_o=1 with gnt_pos_o=granted slot, or gnt_ok_o=0 with gnt_pos_o=0 on fail.
  - The occupancy update lands on the same edge.
- Throughput: back-to-back requests are supported, one grant per cycle. The cycle N+1 decision sees the cycle N grant already in occ.
- Free:
  - Legal when free_vld_i=1, free_pos_i is one-hot and the addressed bit is set: clears the bit at the next edge.
  - Illegal (not one-hot, or slot already free): ignored, err_o pulses for one cycle at N+1, no state change from the free.
- Simultaneous alloc and free in one cycle:
  - The alloc decision uses pre-free occ.
  - next occ = (occ & ~free) | grant.
  - head and cnt_o are recomputed from next occ.
  - A free of the slot being granted that cycle cannot occur, because the granted slot is unoccupied; that case falls under the illegal-free rule.
- Slots released above the head are not re-granted until the head moves:
  - e_cell searches only below head, so the allocator is compacting by construction.
  - Freeing the head moves head down to the next occupied bit.
  - Draining to empty restarts allocation at bit W-1.
- cnt_o = popcount(occ), registered. full_o and empty_o are decoded from registered occ.
- Reset asserted mid-operation: all state clears immediately. Any in-flight grant is dropped, with gnt_vld_o forced to 0.

Decomposition:
- Package e_pkg: `e_cnt_w(W)` function returning $clog2(W)+1, and the supported-width check.
- Sub-modules:
  - One instance of the existing e_cell.
  - One small combinational e_prio (MSB-first one-hot priority encoder), used for head recompute.
- Popcount stays inline.

Test Plan (W=4):
1. Reset: assert arst_n low mid-run -> occ_o=0000, empty_o=1, full_o=0, cnt_o=0, gnt_vld_o=0 immediately, without a clock edge.
2. Four back-to-back alloc_req_i from empty:
   - Grants 1000, 0100, 0010, 0001 in consecutive cycles.
   - full_o=1, cnt_o=4.
   - Fifth request -> gnt_vld_o=1, gnt_ok_o=0, gnt_pos_o=0000.
3. Hole fill:
   - From occ=1110, free 0100 -> occ=1010, head=1000.
   - Alloc -> gnt_pos_o=0100, occ=1110.
4. Head release:
   - From occ=1111, free 1000 -> occ=0111, head=0100.
   - Alloc -> gnt_ok_o=0, because slot 1000 is unreachable.
   - Free 0100, 0010, 0001 -> empty_o=1.
   - Alloc -> gnt_pos_o=1000.
5. Simultaneous: from occ=1100, alloc plus free 1000 in the same cycle -> gnt_pos_o=0010, occ=0110, head=0100, cnt_o=2.
6. Illegal free:
   - Free 0001 with occ=1000 -> err_o pulses one cycle, occ unchanged.
   - Free 0011 -> err_o pulses, occ unchanged.
